// File: rtl/stack_alu_pkg.sv
// Shared types for the stack/ALU engine: command and ALU encodings and the FSM state.
package stack_alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_ALU  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } cmd_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_NOR = 3'd7
    } alu_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WB   = 1'b1
    } state_e;

endpackage

// File: rtl/stack_alu_engine_if.sv
// Command/status bundle between the decoder (master) and the stack/ALU engine (slave).
interface stack_alu_engine_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [2:0]       alu_code;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] alu_result;
    logic             err_clr;
    logic             err_ovf;
    logic             err_udf;
    logic             err_ill;

    modport master (
        output cmd_valid, cmd_op, alu_code, in_val, err_clr,
        input  cmd_ready, top, next, count, alu_result, err_ovf, err_udf, err_ill
    );

    modport slave (
        input  cmd_valid, cmd_op, alu_code, in_val, err_clr,
        output cmd_ready, top, next, count, alu_result, err_ovf, err_udf, err_ill
    );

endinterface

// File: rtl/stack_alu_op.sv
// Combinational ALU for the stack engine; o_legal low for codes not built in.
// Shift codes 5/6 exist only when STACK_ALU_SHIFT_EN is defined.
module stack_alu_op
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_code,
    output logic [WIDTH-1:0] o_y,
    output logic             o_legal
);
`ifdef STACK_ALU_SHIFT_EN
    localparam int SW = $clog2(WIDTH);
`endif

    always_comb begin
        o_y     = '0;
        o_legal = 1'b1;
        case (alu_code_e'(i_code))
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_NOR: o_y = ~(i_a | i_b);
`ifdef STACK_ALU_SHIFT_EN
            ALU_SHL: o_y = i_a << i_b[SW-1:0];
            ALU_SHR: o_y = i_a >> i_b[SW-1:0];
`endif
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/stack_alu_engine.sv
// Data stack + ALU execute unit: 1-cycle stack ops, 2-cycle ALU ops, sticky errors.
// Optional shifter via STACK_ALU_SHIFT_EN (see stack_alu_op).
module stack_alu_engine
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    stack_alu_engine_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_sp;
    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_alu_result;
    logic             r_err_ovf, r_err_udf, r_err_ill;

    logic [AW-1:0]    w_a0, w_a1, w_a2;
    logic             w_empty, w_full, w_lt2;
    logic [WIDTH-1:0] w_top, w_next, w_alu_y;
    logic             w_alu_legal;
    logic             w_sp_inc, w_sp_dec, w_alu_ld;
    logic             w_set_ovf, w_set_udf, w_set_ill;
    logic             w_we0, w_we1;
    logic [AW-1:0]    w_wa0, w_wa1;
    logic [WIDTH-1:0] w_wd0, w_wd1;

    assign w_a0    = r_sp[AW-1:0];
    assign w_a1    = w_a0 - AW'(1);
    assign w_a2    = w_a0 - AW'(2);
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == CW'(DEPTH));
    assign w_lt2   = (r_sp < CW'(2));
    assign w_top   = w_empty ? '0 : r_mem[w_a1];
    assign w_next  = w_lt2   ? '0 : r_mem[w_a2];

    stack_alu_op #(.WIDTH(WIDTH)) u_op (
        .i_a     (w_top),
        .i_b     (w_next),
        .i_code  (bus.alu_code),
        .o_y     (w_alu_y),
        .o_legal (w_alu_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Any offending command only raises flags; every write/advance below is skipped for it.
    always_comb begin
        w_state_nxt = r_state;
        w_sp_inc    = 1'b0;
        w_sp_dec    = 1'b0;
        w_alu_ld    = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_udf   = 1'b0;
        w_set_ill   = 1'b0;
        w_we0       = 1'b0;
        w_wa0       = w_a0;
        w_wd0       = bus.in_val;
        w_we1       = 1'b0;
        w_wa1       = w_a2;
        w_wd1       = w_top;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (cmd_op_e'(bus.cmd_op))
                        OP_NOP: ;
                        OP_PUSH: begin
                            if (w_full) w_set_ovf = 1'b1;
                            else begin
                                w_we0    = 1'b1;
                                w_sp_inc = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (w_empty) w_set_udf = 1'b1;
                            else         w_sp_dec  = 1'b1;
                        end
                        OP_DUP: begin
                            if (w_empty)     w_set_udf = 1'b1;
                            else if (w_full) w_set_ovf = 1'b1;
                            else begin
                                w_we0    = 1'b1;
                                w_wd0    = w_top;
                                w_sp_inc = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (w_lt2) w_set_udf = 1'b1;
                            else begin
                                w_we0 = 1'b1;
                                w_wa0 = w_a1;
                                w_wd0 = w_next;
                                w_we1 = 1'b1;
                            end
                        end
                        OP_ALU: begin
                            w_set_udf = w_lt2;
                            w_set_ill = ~w_alu_legal;
                            if (!w_lt2 && w_alu_legal) begin
                                w_alu_ld    = 1'b1;
                                w_state_nxt = ST_WB;
                            end
                        end
                        default: w_set_ill = 1'b1;
                    endcase
                end
            end
            ST_WB: begin
                w_we0       = 1'b1;
                w_wa0       = w_a2;
                w_wd0       = r_alu_result;
                w_sp_dec    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we0) r_mem[w_wa0] <= w_wd0;
        if (w_we1) r_mem[w_wa1] <= w_wd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp         <= '0;
            r_alu_result <= '0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
            r_err_ill    <= 1'b0;
        end else begin
            if (w_sp_inc)      r_sp <= r_sp + CW'(1);
            else if (w_sp_dec) r_sp <= r_sp - CW'(1);
            if (w_alu_ld) r_alu_result <= w_alu_y;
            r_err_ovf <= (r_err_ovf & ~bus.err_clr) | w_set_ovf;
            r_err_udf <= (r_err_udf & ~bus.err_clr) | w_set_udf;
            r_err_ill <= (r_err_ill & ~bus.err_clr) | w_set_ill;
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.top        = w_top;
    assign bus.next       = w_next;
    assign bus.count      = r_sp;
    assign bus.alu_result = r_alu_result;
    assign bus.err_ovf    = r_err_ovf;
    assign bus.err_udf    = r_err_udf;
    assign bus.err_ill    = r_err_ill;

endmodule

// File: tb/tb_stack_alu_engine.sv
// Self-checking bench for stack_alu_engine (WIDTH=16, DEPTH=16); expectations follow STACK_ALU_SHIFT_EN.
module tb_stack_alu_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_alu_engine_if #(.WIDTH(16), .DEPTH(16)) bus ();

    stack_alu_engine #(.WIDTH(16), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  code;
        logic [15:0] val;
        logic        clr;
        logic [15:0] etop;
        logic [15:0] enext;
        logic [4:0]  ecnt;
        logic [2:0]  eerr;   // {ovf, udf, ill}
        logic        ebusy;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sbq[$];
    logic [15:0] exp_alu;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [2:0] code, input logic [15:0] val,
                       input logic clr, input logic [15:0] etop, input logic [15:0] enext,
                       input logic [4:0] ecnt, input logic [2:0] eerr, input logic ebusy);
        vec_t v;
        v.op = op; v.code = code; v.val = val; v.clr = clr;
        v.etop = etop; v.enext = enext; v.ecnt = ecnt; v.eerr = eerr; v.ebusy = ebusy;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.err_clr   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_alu = 16'h0000;
        sbq.delete();
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] code, input logic [15:0] val,
                         input logic clr);
        int unsigned w;
        w = 0;
        @(negedge clk);
        while (!bus.cmd_ready && w < 10) begin
            w++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) begin
            n_cmp++;
            n_mis++;
            $display("FAIL ready_timeout: got cmd_ready=0 want 1 within 10 cycles");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.alu_code  = code;
        bus.in_val    = val;
        bus.err_clr   = clr;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic finish_cmd(output int busy);
        busy = 0;
        while (!bus.cmd_ready && busy < 8) begin
            busy++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) begin
            n_cmp++;
            n_mis++;
            $display("FAIL wb_timeout: got cmd_ready=0 want 1 after 8 cycles");
        end
    endtask

    task automatic run_table(input string tag);
        vec_t v;
        int   busy;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.ebusy) sbq.push_back(v.etop);
            issue(v.op, v.code, v.val, v.clr);
            finish_cmd(busy);
            chk($sformatf("%s%0d_busy", tag, i), busy, v.ebusy ? 1 : 0);
            if (busy > 0) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL %s%0d_sb: got unexpected ALU writeback want none", tag, i);
                end else begin
                    exp_alu = sbq.pop_front();
                end
            end
            chk($sformatf("%s%0d_top", tag, i), bus.top, v.etop);
            chk($sformatf("%s%0d_next", tag, i), bus.next, v.enext);
            chk($sformatf("%s%0d_count", tag, i), bus.count, v.ecnt);
            chk($sformatf("%s%0d_err", tag, i), {bus.err_ovf, bus.err_udf, bus.err_ill}, v.eerr);
            chk($sformatf("%s%0d_alu", tag, i), bus.alu_result, exp_alu);
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s_sb_left: got %0d pending want 0", tag, sbq.size());
            sbq.delete();
        end
        tbl.delete();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.alu_code  = 3'd0;
        bus.in_val    = 16'h0;
        bus.err_clr   = 1'b0;
        do_reset();

        chk("rst_count", bus.count, 0);
        chk("rst_top", bus.top, 0);
        chk("rst_next", bus.next, 0);
        chk("rst_alu", bus.alu_result, 0);
        chk("rst_err", {bus.err_ovf, bus.err_udf, bus.err_ill}, 3'b000);
        chk("rst_ready", bus.cmd_ready, 1);

        //   op    code  val       clr  top       next      cnt  err     busy
        add(3'd1, 3'd0, 16'h0003, 0, 16'h0003, 16'h0000, 1, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0005, 0, 16'h0005, 16'h0003, 2, 3'b000, 0);
        add(3'd5, 3'd1, 16'h0000, 0, 16'h0002, 16'h0000, 1, 3'b000, 1);
        add(3'd1, 3'd0, 16'hFFFF, 0, 16'hFFFF, 16'h0002, 2, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0001, 0, 16'h0001, 16'hFFFF, 3, 3'b000, 0);
        add(3'd5, 3'd0, 16'h0000, 0, 16'h0000, 16'h0002, 2, 3'b000, 1);
        add(3'd1, 3'd0, 16'h00F0, 0, 16'h00F0, 16'h0000, 3, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0F3C, 0, 16'h0F3C, 16'h00F0, 4, 3'b000, 0);
        add(3'd5, 3'd2, 16'h0000, 0, 16'h0030, 16'h0000, 3, 3'b000, 1);
        add(3'd1, 3'd0, 16'h1234, 0, 16'h1234, 16'h0030, 4, 3'b000, 0);
        add(3'd5, 3'd4, 16'h0000, 0, 16'h1204, 16'h0000, 3, 3'b000, 1);
        add(3'd3, 3'd0, 16'h0000, 0, 16'h1204, 16'h1204, 4, 3'b000, 0);
        add(3'd5, 3'd7, 16'h0000, 0, 16'hEDFB, 16'h0000, 3, 3'b000, 1);
        add(3'd4, 3'd0, 16'h0000, 0, 16'h0000, 16'hEDFB, 3, 3'b000, 0);
        add(3'd5, 3'd1, 16'h0000, 0, 16'h1205, 16'h0002, 2, 3'b000, 1);
        add(3'd2, 3'd0, 16'h0000, 0, 16'h0002, 16'h0000, 1, 3'b000, 0);
        add(3'd5, 3'd3, 16'h0000, 0, 16'h0002, 16'h0000, 1, 3'b010, 0);
        add(3'd0, 3'd0, 16'h0000, 1, 16'h0002, 16'h0000, 1, 3'b000, 0);
        add(3'd6, 3'd0, 16'h0000, 0, 16'h0002, 16'h0000, 1, 3'b001, 0);
        add(3'd7, 3'd0, 16'h0000, 1, 16'h0002, 16'h0000, 1, 3'b001, 0);
        add(3'd2, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'b001, 0);
        add(3'd2, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'b011, 0);
        add(3'd3, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3'b011, 0);
`ifdef STACK_ALU_SHIFT_EN
        add(3'd5, 3'd5, 16'h0000, 1, 16'h0000, 16'h0000, 0, 3'b010, 0);
`else
        add(3'd5, 3'd5, 16'h0000, 1, 16'h0000, 16'h0000, 0, 3'b011, 0);
`endif
        add(3'd0, 3'd0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 3'b000, 0);
        run_table("basic");

        // Fill to DEPTH, then overflow, SWAP at full, clear, ALU at full.
        do_reset();
        for (int i = 0; i < 16; i++)
            add(3'd1, 3'd0, 16'h0100 + 16'(i), 0, 16'h0100 + 16'(i),
                (i == 0) ? 16'h0000 : 16'h00FF + 16'(i), 5'(i + 1), 3'b000, 0);
        add(3'd1, 3'd0, 16'hAAAA, 0, 16'h010F, 16'h010E, 16, 3'b100, 0);
        add(3'd3, 3'd0, 16'h0000, 0, 16'h010F, 16'h010E, 16, 3'b100, 0);
        add(3'd4, 3'd0, 16'h0000, 0, 16'h010E, 16'h010F, 16, 3'b100, 0);
        add(3'd0, 3'd0, 16'h0000, 1, 16'h010E, 16'h010F, 16, 3'b000, 0);
        add(3'd5, 3'd1, 16'h0000, 0, 16'hFFFF, 16'h010D, 15, 3'b000, 1);
        run_table("full");

        // Reset asserted while the engine sits in the writeback cycle.
        do_reset();
        add(3'd1, 3'd0, 16'h0007, 0, 16'h0007, 16'h0000, 1, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0009, 0, 16'h0009, 16'h0007, 2, 3'b000, 0);
        run_table("pre_wb");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd5;
        bus.alu_code  = 3'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("wb_ready_low", bus.cmd_ready, 0);
        rst = 1'b1;
        #1;
        chk("wb_rst_count", bus.count, 0);
        chk("wb_rst_top", bus.top, 0);
        chk("wb_rst_ready", bus.cmd_ready, 1);
        chk("wb_rst_alu", bus.alu_result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("wb_post_count", bus.count, 0);
        chk("wb_post_ready", bus.cmd_ready, 1);
        exp_alu = 16'h0000;

        // Shift behaviour depends on the build.
        do_reset();
        add(3'd1, 3'd0, 16'h0002, 0, 16'h0002, 16'h0000, 1, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0001, 0, 16'h0001, 16'h0002, 2, 3'b000, 0);
`ifdef STACK_ALU_SHIFT_EN
        add(3'd5, 3'd5, 16'h0000, 0, 16'h0004, 16'h0000, 1, 3'b000, 1);
        add(3'd1, 3'd0, 16'h0003, 0, 16'h0003, 16'h0004, 2, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0080, 0, 16'h0080, 16'h0003, 3, 3'b000, 0);
        add(3'd5, 3'd6, 16'h0000, 0, 16'h0010, 16'h0004, 2, 3'b000, 1);
        add(3'd1, 3'd0, 16'h0013, 0, 16'h0013, 16'h0010, 3, 3'b000, 0);
        add(3'd1, 3'd0, 16'h0001, 0, 16'h0001, 16'h0013, 4, 3'b000, 0);
        add(3'd5, 3'd5, 16'h0000, 0, 16'h0008, 16'h0010, 3, 3'b000, 1);
`else
        add(3'd5, 3'd5, 16'h0000, 0, 16'h0001, 16'h0002, 2, 3'b001, 0);
        add(3'd5, 3'd6, 16'h0000, 1, 16'h0001, 16'h0002, 2, 3'b001, 0);
        add(3'd0, 3'd0, 16'h0000, 1, 16'h0001, 16'h0002, 2, 3'b000, 0);
        add(3'd5, 3'd0, 16'h0000, 0, 16'h0003, 16'h0000, 1, 3'b000, 1);
`endif
        run_table("shift");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
